// File: rtl/qarma_cell_shuffler.sv
// Iterative QARMA cell shuffler: applies tau, tau^-1, h or h^-1 to a 16-cell state in_count times.
// Optional macro QARMA_SHUF_INV_EN adds the inverse networks; without it in_mode[0] is ignored.
module qarma_cell_shuffler #(
    parameter  int CELL_W = 4,
    localparam int N      = 16 * CELL_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    input  logic [1:0]   in_mode,
    input  logic [3:0]   in_count,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] P_TAU [16] = '{4'd0, 4'd11, 4'd6, 4'd13, 4'd10, 4'd1, 4'd12, 4'd7,
                                          4'd5, 4'd14, 4'd3, 4'd8, 4'd15, 4'd4, 4'd9, 4'd2};
    localparam logic [3:0] P_H   [16] = '{4'd6, 4'd5, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2, 4'd3,
                                          4'd7, 4'd12, 4'd13, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11};
`ifdef QARMA_SHUF_INV_EN
    localparam logic [3:0] P_TAU_INV [16] = '{4'd0, 4'd5, 4'd15, 4'd10, 4'd13, 4'd8, 4'd2, 4'd7,
                                              4'd11, 4'd14, 4'd4, 4'd1, 4'd6, 4'd3, 4'd9, 4'd12};
    localparam logic [3:0] P_H_INV   [16] = '{4'd4, 4'd5, 4'd6, 4'd7, 4'd11, 4'd1, 4'd0, 4'd8,
                                              4'd12, 4'd13, 4'd14, 4'd15, 4'd9, 4'd10, 4'd2, 4'd3};
`endif

    state_t         r_state;
    state_t         w_state_next;
    logic [N-1:0]   r_data;
    logic [1:0]     r_mode;
    logic [3:0]     r_rem;
    logic           w_accept;
    logic [N-1:0]   w_tau;
    logic [N-1:0]   w_h;
    logic [N-1:0]   w_perm;
`ifdef QARMA_SHUF_INV_EN
    logic [N-1:0]   w_tau_inv;
    logic [N-1:0]   w_h_inv;
`endif

    // Cell 0 sits in the most significant CELL_W bits.
    for (genvar gi = 0; gi < 16; gi++) begin : g_cell
        assign w_tau[N-1-gi*CELL_W -: CELL_W] = r_data[N-1-int'(P_TAU[gi])*CELL_W -: CELL_W];
        assign w_h[N-1-gi*CELL_W -: CELL_W]   = r_data[N-1-int'(P_H[gi])*CELL_W -: CELL_W];
`ifdef QARMA_SHUF_INV_EN
        assign w_tau_inv[N-1-gi*CELL_W -: CELL_W] = r_data[N-1-int'(P_TAU_INV[gi])*CELL_W -: CELL_W];
        assign w_h_inv[N-1-gi*CELL_W -: CELL_W]   = r_data[N-1-int'(P_H_INV[gi])*CELL_W -: CELL_W];
`endif
    end

    always_comb begin
        w_perm = w_tau;
`ifdef QARMA_SHUF_INV_EN
        case (r_mode)
            2'd0:    w_perm = w_tau;
            2'd1:    w_perm = w_tau_inv;
            2'd2:    w_perm = w_h;
            default: w_perm = w_h_inv;
        endcase
`else
        case (r_mode)
            2'd0, 2'd1: w_perm = w_tau;
            default:    w_perm = w_h;
        endcase
`endif
    end

    assign w_accept = in_valid & (r_state == S_IDLE) & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A zero count still spends one RUN cycle, so latency is max(count,1) for every request.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) w_state_next = S_RUN;
                S_RUN:  if (r_rem <= 4'd1) w_state_next = S_DONE;
                S_DONE: if (out_ready) w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_mode <= 2'd0;
            r_rem  <= 4'd0;
        end else if (w_accept) begin
            r_data <= in_data;
            r_mode <= in_mode;
            r_rem  <= in_count;
        end else if ((r_state == S_RUN) && !flush && (r_rem != 4'd0)) begin
            r_data <= w_perm;
            r_rem  <= r_rem - 4'd1;
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_data  = r_data;

endmodule

// File: tb/tb_qarma_cell_shuffler.sv
// Directed self-checking bench for qarma_cell_shuffler (CELL_W=4 and CELL_W=8 instances).
module tb_qarma_cell_shuffler;

    localparam logic [63:0] V_PLAIN = 64'h0123456789ABCDEF;
    localparam logic [63:0] V_TAU1  = 64'h0B6DA1C75E38F492;
    localparam logic [63:0] V_TAU2  = 64'h08C43BF719D52AE6;
    localparam logic [63:0] V_H1    = 64'h65EF01237CD489AB;
    localparam logic [63:0] V_H2    = 64'h21AB65EF38907CD4;
`ifdef QARMA_SHUF_INV_EN
    localparam logic [63:0] EXP_TAU_INV = V_PLAIN;
    localparam logic [63:0] EXP_H_INV   = V_PLAIN;
`else
    localparam logic [63:0] EXP_TAU_INV = V_TAU2;
    localparam logic [63:0] EXP_H_INV   = V_H2;
`endif
    localparam logic [127:0] V8_PLAIN = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] V8_TAU1  = 128'h00BB66DDAA11CC7755EE3388FF449922;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [1:0]  in_mode;
    logic [3:0]  in_count;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    logic         b_flush;
    logic         b_in_valid;
    logic         b_in_ready;
    logic [127:0] b_in_data;
    logic [1:0]   b_in_mode;
    logic [3:0]   b_in_count;
    logic         b_out_valid;
    logic         b_out_ready;
    logic [127:0] b_out_data;
    logic         b_busy;

    int checks = 0;
    int errors = 0;

    qarma_cell_shuffler #(.CELL_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_count(in_count),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy)
    );

    qarma_cell_shuffler #(.CELL_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_mode(b_in_mode), .in_count(b_in_count),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE; returns the result and edges from accept to out_valid.
    task automatic run_req(input logic [63:0] d, input logic [1:0] m, input logic [3:0] c,
                           output logic [63:0] res, output int lat);
        in_data  = d;
        in_mode  = m;
        in_count = c;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_mode  = ~m;
        in_data  = '0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        res = out_data;
        $display("req mode=%0d count=%0d in=%h out=%h latency=%0d", m, c, d, res, lat);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_tau();
        logic [63:0] res;
        int lat;
        run_req(V_PLAIN, 2'd0, 4'd1, res, lat);
        checks++; if (res !== V_TAU1) begin errors++; $display("FAIL tau_data: got %h expected %h", res, V_TAU1); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL tau_latency: got %0d expected 1", lat); end
        release_out();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL tau_handoff: got in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        run_req(V_PLAIN, 2'd0, 4'd2, res, lat);
        checks++; if (res !== V_TAU2) begin errors++; $display("FAIL tau2_mode_hold: got %h expected %h", res, V_TAU2); end
        release_out();
    endtask

    task automatic test_inverse();
        logic [63:0] res;
        int lat;
        run_req(V_TAU1, 2'd1, 4'd1, res, lat);
        checks++; if (res !== EXP_TAU_INV) begin errors++; $display("FAIL tau_inv_data: got %h expected %h", res, EXP_TAU_INV); end
        release_out();
        run_req(V_H1, 2'd3, 4'd1, res, lat);
        checks++; if (res !== EXP_H_INV) begin errors++; $display("FAIL h_inv_data: got %h expected %h", res, EXP_H_INV); end
        release_out();
    endtask

    task automatic test_h();
        logic [63:0] res;
        int lat;
        run_req(V_PLAIN, 2'd2, 4'd2, res, lat);
        checks++; if (res !== V_H2) begin errors++; $display("FAIL h2_data: got %h expected %h", res, V_H2); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL h2_latency: got %0d expected 2", lat); end
        release_out();
        run_req(V_PLAIN, 2'd2, 4'd0, res, lat);
        checks++; if (res !== V_PLAIN) begin errors++; $display("FAIL count0_data: got %h expected %h", res, V_PLAIN); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL count0_latency: got %0d expected 1", lat); end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [63:0] res;
        int lat;
        int bad;
        run_req(V_PLAIN, 2'd0, 4'd1, res, lat);
        in_valid = 1'b1;
        in_data  = V_H1;
        in_count = 4'd3;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (out_data !== V_TAU1 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL backpressure_hold: got %0d bad cycles expected 0", bad); end
        in_valid = 1'b0;
        release_out();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL backpressure_release: got in_ready=%b busy=%b expected 1/0", in_ready, busy); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        in_data   = V_PLAIN;
        in_mode   = 2'd0;
        in_count  = 4'd1;
        in_valid  = 1'b1;
        step();
        in_data = V_TAU1;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== V_TAU1) begin
            errors++; $display("FAIL b2b_first: got valid=%b data=%h expected 1/%h", out_valid, out_data, V_TAU1); end
        step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", in_ready); end
        step();
        in_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || out_data !== V_TAU2) begin
            errors++; $display("FAIL b2b_second: got valid=%b data=%h expected 1/%h", out_valid, out_data, V_TAU2); end
        step();
        out_ready = 1'b0;
        $display("back-to-back pair done");
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int lat;
        int seen;
        in_data  = V_PLAIN;
        in_mode  = 2'd0;
        in_count = 4'd10;
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_vs_accept: got busy=%b in_ready=%b expected 0/1", busy, in_ready); end
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush_run_busy: got %b expected 1", busy); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_in_run: got busy=%b in_ready=%b expected 0/1", busy, in_ready); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_valid: got %0d valid cycles expected 0", seen); end
        run_req(V_PLAIN, 2'd2, 4'd2, res, lat);
        checks++; if (res !== V_H2 || lat !== 2) begin
            errors++; $display("FAIL flush_fresh_req: got %h lat %0d expected %h lat 2", res, lat, V_H2); end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        in_data  = V_PLAIN;
        in_mode  = 2'd2;
        in_count = 4'd10;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_run_busy: got %b expected 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out_data !== 64'h0) begin
            errors++; $display("FAIL rst_mid_run: got valid=%b busy=%b ready=%b data=%h expected 0/0/1/0",
                               out_valid, busy, in_ready, out_data); end
        #2;
        rst_n = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_after_release: got busy=%b expected 0", busy); end
    endtask

    task automatic test_cell8();
        int lat;
        b_in_data  = V8_PLAIN;
        b_in_mode  = 2'd0;
        b_in_count = 4'd1;
        b_in_valid = 1'b1;
        step();
        b_in_valid = 1'b0;
        b_in_mode  = 2'd3;
        lat = 0;
        while (!b_out_valid && lat < 40) begin
            step();
            lat++;
        end
        $display("req8 mode=0 count=1 in=%h out=%h latency=%0d", V8_PLAIN, b_out_data, lat);
        checks++; if (b_out_data !== V8_TAU1) begin errors++; $display("FAIL cell8_tau: got %h expected %h", b_out_data, V8_TAU1); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL cell8_latency: got %0d expected 1", lat); end
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 2'd0; in_count = 4'd0; out_ready = 1'b0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 2'd0; b_in_count = 4'd0; b_out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        test_reset();
        test_tau();
        test_inverse();
        test_h();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_run();
        test_cell8();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
